// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs,
// 0xF4 enable-streaming, 0xFF reset) to a keyboard or mouse. It lives in the
// clk_32 domain of the ps2 receive decoder and uses the same 2 MHz ena_2m tick.
// The PS/2 lines are open-collector: this block only produces pull-low enables
// and the top level turns them into tristate pins.
//
// Build option:
//   PS2_TX_RETRY_EN - when defined, a failed transfer (timeout or missing ack)
//                     is restarted from INHIBIT with the latched byte, up to
//                     two retries; error pulses only after the third failure.
//                     When undefined, error pulses on the first failure.
//
// Ports:
//   clk          in   system clock (clk_32)
//   reset_n      in   asynchronous active-low reset
//   ena_2m       in   2 MHz clock-enable strobe, one clk wide
//   tx_data[7:0] in   command byte
//   tx_valid     in   request to send tx_data
//   tx_ready     out  high in IDLE; accept on tx_valid && tx_ready
//   ps2_clk_in   in   raw PS/2 clock line level
//   ps2_data_in  in   raw PS/2 data line level
//   ps2_clk_oe   out  1 = pull clock line low
//   ps2_data_oe  out  1 = pull data line low
//   busy         out  high from accept until return to IDLE
//   done         out  one-clk pulse: byte sent and acknowledged
//   error        out  one-clk pulse: timeout or missing ack
//
// States:
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | lines released, waiting for tx_valid
//   INHIBIT   | clock held low for INHIBIT_TICKS to request-to-send
//   START     | clock released, data low (start bit), waiting first fall
//   DATA      | each fall drives the next data bit, LSB first, then parity
//   STOP_BIT  | next fall releases data (stop bit = 1)
//   ACK       | next fall samples the device ack on the data line
//   RELEASE   | wait for both lines idle high, then pulse done
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_TICKS = 200,
    parameter int TIMEOUT_TICKS = 30000,
    parameter int FILTER_LEN    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ena_2m,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INHIBIT  = 3'd1,
        S_START    = 3'd2,
        S_DATA     = 3'd3,
        S_STOP_BIT = 3'd4,
        S_ACK      = 3'd5,
        S_RELEASE  = 3'd6
    } state_t;

    localparam logic [14:0] INHIBIT_C = 15'(INHIBIT_TICKS);
    localparam logic [14:0] TIMEOUT_C = 15'(TIMEOUT_TICKS);

    // ------------------------------------------------------------------
    // Input conditioning: two-flop synchronisers, then a clock glitch
    // filter that only changes level after FILTER_LEN equal samples.
    // ------------------------------------------------------------------
    logic [1:0]            r_clk_sync;
    logic [1:0]            r_data_sync;
    logic [FILTER_LEN-1:0] r_filt_sh;
    logic                  r_clk_filt;
    logic                  r_fall;
    logic [FILTER_LEN-1:0] w_filt_next;
    logic                  w_data_s;

    assign w_filt_next = {r_filt_sh[FILTER_LEN-2:0], r_clk_sync[1]};
    assign w_data_s    = r_data_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_filt_sh   <= '1;
            r_clk_filt  <= 1'b1;
            r_fall      <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
            r_data_sync <= {r_data_sync[0], ps2_data_in};
            r_fall      <= 1'b0;
            if (ena_2m) begin
                r_filt_sh <= w_filt_next;
                if (w_filt_next == '0) begin
                    r_clk_filt <= 1'b0;
                    r_fall     <= r_clk_filt;
                end else if (w_filt_next == '1) begin
                    r_clk_filt <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [7:0]  r_byte;
    logic        r_parity;
    logic [3:0]  r_bit_idx;
    logic [14:0] r_tick_cnt;
    logic        r_clk_oe;
    logic        r_data_oe;
    logic        r_tx_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]  r_retry_cnt;
`endif

    logic [14:0] w_tick_next;
    logic        w_timeout;
    logic        w_line_idle;
    logic        w_fail;

    // Saturating tick counter: a stuck device can never wrap it back
    // below the timeout threshold.
    assign w_tick_next = (ena_2m && (r_tick_cnt != '1)) ? r_tick_cnt + 15'd1 : r_tick_cnt;
    assign w_timeout   = (r_tick_cnt >= TIMEOUT_C);
    assign w_line_idle = r_clk_filt && w_data_s;

    // A fall always restarts the timeout window, so it wins over an
    // expiring counter in the same cycle. In ACK a fall with data high
    // is the missing-ack failure.
    always_comb begin
        w_fail = 1'b0;
        case (r_state)
            S_START, S_DATA, S_STOP_BIT: w_fail = !r_fall && w_timeout;
            S_ACK:                       w_fail = r_fall ? w_data_s : w_timeout;
            S_RELEASE:                   w_fail = !r_fall && !w_line_idle && w_timeout;
            default:                     w_fail = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_byte     <= '0;
            r_parity   <= 1'b0;
            r_bit_idx  <= '0;
            r_tick_cnt <= '0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            r_retry_cnt <= '0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_tick_cnt <= w_tick_next;

            if (w_fail) begin
                r_clk_oe   <= 1'b0;
                r_data_oe  <= 1'b0;
                r_tick_cnt <= '0;
`ifdef PS2_TX_RETRY_EN
                if (r_retry_cnt != 2'd2) begin
                    // Restart the whole request-to-send with the latched byte.
                    r_retry_cnt <= r_retry_cnt + 2'd1;
                    r_clk_oe    <= 1'b1;
                    r_state     <= S_INHIBIT;
                end else begin
                    r_error    <= 1'b1;
                    r_busy     <= 1'b0;
                    r_tx_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
`else
                r_error    <= 1'b1;
                r_busy     <= 1'b0;
                r_tx_ready <= 1'b1;
                r_state    <= S_IDLE;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        if (tx_valid && r_tx_ready) begin
                            r_byte     <= tx_data;
                            r_parity   <= ~^tx_data;
                            r_tick_cnt <= '0;
                            r_clk_oe   <= 1'b1;
                            r_tx_ready <= 1'b0;
                            r_busy     <= 1'b1;
`ifdef PS2_TX_RETRY_EN
                            r_retry_cnt <= '0;
`endif
                            r_state    <= S_INHIBIT;
                        end
                    end

                    S_INHIBIT: begin
                        if (r_tick_cnt >= INHIBIT_C) begin
                            // Start bit goes low as the clock is released.
                            r_clk_oe   <= 1'b0;
                            r_data_oe  <= 1'b1;
                            r_tick_cnt <= '0;
                            r_state    <= S_START;
                        end
                    end

                    S_START: begin
                        if (r_fall) begin
                            r_data_oe  <= ~r_byte[0];
                            r_bit_idx  <= 4'd1;
                            r_tick_cnt <= '0;
                            r_state    <= S_DATA;
                        end
                    end

                    S_DATA: begin
                        if (r_fall) begin
                            r_tick_cnt <= '0;
                            if (r_bit_idx == 4'd8) begin
                                r_data_oe <= ~r_parity;
                                r_state   <= S_STOP_BIT;
                            end else begin
                                r_data_oe <= ~r_byte[r_bit_idx[2:0]];
                                r_bit_idx <= r_bit_idx + 4'd1;
                            end
                        end
                    end

                    S_STOP_BIT: begin
                        if (r_fall) begin
                            r_data_oe  <= 1'b0;
                            r_tick_cnt <= '0;
                            r_state    <= S_ACK;
                        end
                    end

                    S_ACK: begin
                        // Reaching here on a fall means the ack was low.
                        if (r_fall) begin
                            r_tick_cnt <= '0;
                            r_state    <= S_RELEASE;
                        end
                    end

                    S_RELEASE: begin
                        if (w_line_idle) begin
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_tx_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end else if (r_fall) begin
                            r_tick_cnt <= '0;
                        end
                    end

                    default: begin
                        r_clk_oe   <= 1'b0;
                        r_data_oe  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = r_tx_ready;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 200;
    localparam int TMO  = 1000;
    localparam int HALF = 160;   // device half period in clk cycles (80 ticks)
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ena_2m = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error;
    logic       dev_clk_drv = 1'b0;
    logic       dev_dat_drv = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(ps2_clk_oe  | dev_clk_drv);
    assign ps2_data_line = ~(ps2_data_oe | dev_dat_drv);

    ps2_host_tx #(
        .INHIBIT_TICKS(INH),
        .TIMEOUT_TICKS(TMO),
        .FILTER_LEN   (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ena_2m     (ena_2m),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ena_2m <= ~ena_2m;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] b;
        bit         par;
    } exp_t;
    exp_t exp_q[$];

    // device model state
    int         dev_mode = 0;     // 0 ack, 1 never clocks, 2 no ack
    bit         dev_glitch = 0;
    bit         dev_abort = 0;
    bit         dev_busy = 0;
    int         dev_falls = 0;
    logic [7:0] dev_bits = 8'h00;
    logic       dev_start = 1'b1, dev_par = 1'b0, dev_stop = 1'b0;
    bit         seen_inh = 0;
    int         inh_count = 0;
    int         inh_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // PS/2 device: generates 11 clocks after a request-to-send and samples
    // data on each rising edge; optionally acks and injects clock glitches.
    task automatic run_frame();
        dev_busy  = 1;
        dev_falls = 0;
        repeat (100) @(posedge clk);
        dev_start = ps2_data_line;
        for (int k = 1; k <= 11; k++) begin
            if (dev_abort) break;
            dev_clk_drv = 1'b1;
            dev_falls   = k;
            repeat (HALF) @(posedge clk);
            dev_clk_drv = 1'b0;
            if (k == 11)     dev_dat_drv = 1'b0;
            else if (k <= 8) dev_bits[k-1] = ps2_data_line;
            else if (k == 9) dev_par = ps2_data_line;
            else             dev_stop = ps2_data_line;
            if (dev_glitch && (k == 3 || k == 6)) begin
                repeat (40) @(posedge clk);
                dev_clk_drv = 1'b1;
                repeat (4) @(posedge clk);
                dev_clk_drv = 1'b0;
                repeat (HALF - 44) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            if (k == 10 && dev_mode == 0) dev_dat_drv = 1'b1;
        end
        dev_clk_drv = 1'b0;
        dev_dat_drv = 1'b0;
        dev_busy    = 0;
    endtask

    initial begin : device
        forever begin
            @(posedge clk);
            if (ps2_clk_oe) seen_inh = 1;
            else if (seen_inh) begin
                seen_inh = 0;
                if (dev_mode != 1 && !dev_abort) run_frame();
            end
        end
    end

    // inhibit period monitor: length and number of request-to-send attempts
    initial begin : inhibit_mon
        forever begin
            @(negedge clk);
            if (ps2_clk_oe) inh_len++;
            else if (inh_len > 0) begin
                inh_count++;
                check("inhibit_len_in_range", (inh_len >= 2*INH-4) && (inh_len <= 2*INH+4), 1);
                inh_len = 0;
            end
        end
    end

    // scoreboard monitor
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (done || error) begin
                exp_t e;
                check("done_error_exclusive", done & error, 0);
                check("pending_expectation", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("completion_is_error", error, e.is_err);
                    if (e.is_err) begin
                        check("attempts_before_error", inh_count, ATTEMPTS);
                    end else begin
                        check("start_bit", dev_start, 0);
                        check("data_byte", dev_bits, e.b);
                        check("parity_bit", dev_par, e.par);
                        check("stop_bit", dev_stop, 1);
                        check("attempts_on_success", inh_count, 1);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit par, input int mode,
                        input bit glitch, input bit exp_err, input bit push);
        int waitc;
        exp_t e;
        dev_mode   = mode;
        dev_glitch = glitch;
        inh_count  = 0;
        if (push) begin
            e.is_err = exp_err;
            e.b      = b;
            e.par    = par;
            exp_q.push_back(e);
        end
        waitc = 0;
        while (!tx_ready && waitc < 1000) begin
            @(negedge clk);
            waitc++;
        end
        check("tx_ready_before_send", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_drops", tx_ready, 0);
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_idle();
        int waitc;
        waitc = 0;
        while (busy && waitc < 20000) begin
            @(negedge clk);
            waitc++;
        end
        check("transfer_finished_in_budget", busy, 0);
        waitc = 0;
        while (dev_busy && waitc < 5000) begin
            @(negedge clk);
            waitc++;
        end
        check("device_idle_in_budget", dev_busy, 0);
        repeat (50) @(negedge clk);
        check("idle_tx_ready", tx_ready, 1);
        check("idle_clk_oe", ps2_clk_oe, 0);
        check("idle_data_oe", ps2_data_oe, 0);
    endtask

    initial begin : main
        int waitc;
        // reset state
        repeat (5) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        // 1: 0xED acked, parity 1
        send(8'hED, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        wait_idle();

        // 2: 0xF4 acked, parity 0; a request while busy is ignored
        send(8'hF4, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        repeat (1500) @(negedge clk);
        check("busy_mid_transfer", busy, 1);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();

        // 3: 0xFF, device never clocks -> timeout error
        send(8'hFF, 1'b1, 1, 1'b0, 1'b1, 1'b1);
        wait_idle();

        // 4: 0xFF, device never acks -> error, no done
        send(8'hFF, 1'b1, 2, 1'b0, 1'b1, 1'b1);
        wait_idle();

        // 5: 0xA5 with short clock glitches mid-byte, parity 1
        send(8'hA5, 1'b1, 0, 1'b1, 1'b0, 1'b1);
        wait_idle();

        // 6: reset during DATA bit 4 of 0x0F (bit4 = 0, data pulled low)
        send(8'h0F, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        waitc = 0;
        while (dev_falls != 5 && waitc < 10000) begin
            @(negedge clk);
            waitc++;
        end
        check("reached_bit4_fall", dev_falls, 5);
        repeat (40) @(negedge clk);
        check("bit4_data_oe_before_reset", ps2_data_oe, 1);
        #2;
        reset_n   = 1'b0;
        dev_abort = 1;
        #1;
        check("async_reset_clk_oe", ps2_clk_oe, 0);
        check("async_reset_data_oe", ps2_data_oe, 0);
        check("async_reset_busy", busy, 0);
        waitc = 0;
        while (dev_busy && waitc < 5000) begin
            @(negedge clk);
            waitc++;
        end
        check("device_abort_in_budget", dev_busy, 0);
        dev_abort = 0;
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);
        check("post_reset_tx_ready", tx_ready, 1);
        send(8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        wait_idle();

        repeat (20) @(negedge clk);
        check("no_outstanding_expectations", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends command bytes from the core to the keyboard or mouse port, for example 0xED set-LEDs, 0xF4 enable-streaming and 0xFF reset. It is the opposite direction of the existing ps2 receive decoder and shares that decoder's clk_32 domain and 2 MHz ena_2m tick. It drives the open-collector PS/2 clock and data lines via output-enables; the top level converts these to tristate pins.

Parameters:
INHIBIT_TICKS, 200, ena_2m ticks the clock is held low before start (100 us).
TIMEOUT_TICKS, 30000, max ena_2m ticks between device clock falling edges (15 ms).
FILTER_LEN, 8, number of consecutive equal ena_2m samples needed to change the filtered clock.

Ports:
clk  in  1  system clock (clk_32)
reset_n  in  1  asynchronous active-low reset
ena_2m  in  1  2 MHz clock-enable strobe, one clk wide
tx_data  in  8  command byte
tx_valid  in  1  request to send tx_data
tx_ready  out  1  high in IDLE; transfer accepted when tx_valid && tx_ready
ps2_clk_in  in  1  raw PS/2 clock line level
ps2_data_in  in  1  raw PS/2 data line level
ps2_clk_oe  out  1  1 = pull clock line low
ps2_data_oe  out  1  1 = pull data line low
busy  out  1  high from accept until return to IDLE
done  out  1  one-clk pulse: byte sent and acknowledged
error  out  1  one-clk pulse: timeout or missing ack

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, tx_ready=1.
  - ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, error=0.
  - Filter shift register all ones, filtered clock=1.
  - Reset mid-transfer releases both lines immediately.
- Clock filter:
  - On each ena_2m, shift ps2_clk_in into a FILTER_LEN register.
  - Filtered clock goes 0 when all bits are 0, and 1 when all bits are 1; otherwise it holds.
  - A falling edge (fall) is a one-clk strobe on a filtered 1->0 transition.
- ps2_data_in is double-flopped and not filtered.
- Accept: when tx_valid && tx_ready, latch tx_data, compute odd parity (parity = ~^tx_data), clear tick counter, go to INHIBIT. tx_ready drops the next clk.
- States:
  - IDLE: both oe=0.
  - INHIBIT: clk_oe=1. Count ena_2m ticks; at INHIBIT_TICKS assert data_oe=1 (start bit) and go to START.
  - START: clk_oe=0, data_oe=1. On fall, drive bit0 (data_oe=~tx_data[0]), set bit index to 1, go to DATA.
  - DATA: on each fall, drive tx_data[idx] LSB-first. After the fall that drives bit7, the next fall drives parity and goes to STOP_BIT.
  - STOP_BIT: on fall, release data (data_oe=0, stop=1) and go to ACK.
  - ACK: on fall, sample synced data. 0 means ack, go to RELEASE; 1 means error and go to IDLE.
  - RELEASE: wait until filtered clock=1 and synced data=1, then pulse done and go to IDLE.
- Timeout:
  - The counter resets on every fall and at each state entry.
  - In START, DATA, STOP_BIT, ACK and RELEASE, reaching TIMEOUT_TICKS ena_2m ticks releases both lines, pulses error and returns to IDLE.
- The tick counter is 15 bits and saturates; it never wraps.
- Data changes only in response to fall, i.e. while the device holds the clock low. The device samples on the rising edge.
- tx_valid while busy is ignored; the byte is not queued.
- done and error are never asserted in the same cycle.

Optional Feature:
PS2_TX_RETRY_EN
- Defined: on an error (timeout or missing ack), the latched byte is resent automatically from INHIBIT, up to 2 retries. error pulses only after the third failed attempt. busy stays high throughout.
- Undefined: there is no retry and error pulses on the first failure.

Test Plan:
1. Send 0xED with a device model clocking at 12.5 kHz (80 us period) that acks.
   -> clk_oe low for 200 ticks, then start 0 and bits 1,0,1,1,0,1,1,1.
   -> Parity 1, stop 1, then done pulse, busy low, tx_ready high.
2. Send 0xF4 with ack -> data bits 0,0,1,0,1,1,1,1, parity 0, done=1, error=0.
3. Send 0xFF; the device never clocks -> after 30000 ticks past START: error pulse, clk_oe=0, data_oe=0, state IDLE.
4. Send 0xFF; the device leaves data high at the 11th fall -> error pulse with no done.
   -> With PS2_TX_RETRY_EN, three full inhibit/start sequences occur before error.
5. Inject 2-tick low glitches on ps2_clk_in mid-byte -> no extra bits shifted; the byte completes correctly.
6. Assert reset_n=0 during DATA bit 4 -> both oe=0 asynchronously; after release tx_ready=1, and the next send of 0x00 completes with parity 1.
